// File: rtl/ahb_edge_ctrl.sv
// rtl/ahb_edge_ctrl.sv - AHB-Lite configuration slave for the edge-detection accelerator
module ahb_edge_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic        decode_size_enable,
  output logic        decode_source_enable,
  output logic        decode_dest_enable,
  output logic        start,
  input  logic        core_done,
  output logic        busy,
  output logic [2:0]  cfg_valid
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RUNNING = 1'b1
  } state_t;

  // Register index is the word offset inside the 32-byte window
  localparam logic [2:0] IDX_SIZE   = 3'd0;
  localparam logic [2:0] IDX_SRC    = 3'd1;
  localparam logic [2:0] IDX_DST    = 3'd2;
  localparam logic [2:0] IDX_CTRL   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  state_t      state_q, state_d;
  logic        dphase_q, dphase_d;
  logic [4:0]  offset_q, offset_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic        err2_q, err2_d;
  logic        start_q, start_d;
  logic [2:0]  cfg_valid_q, cfg_valid_d;

  logic        accept;
  logic        busy_now;
  logic [2:0]  reg_idx;
  logic        is_cfg, is_ctrl, is_status, unmapped;
  logic        illegal, ok_now, wr_ok, start_req;
  logic [2:0]  cfg_en;
  logic        unused_inputs;

  // Only bit0 of the write data and bit1 of HTRANS carry meaning here
  assign unused_inputs = ^{HWDATA[31:1], HTRANS[0]};

  // State register; synchronous reset returns every flop to its idle value
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      dphase_q    <= 1'b0;
      offset_q    <= 5'd0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      err2_q      <= 1'b0;
      start_q     <= 1'b0;
      cfg_valid_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      dphase_q    <= dphase_d;
      offset_q    <= offset_d;
      write_q     <= write_d;
      size_q      <= size_d;
      err2_q      <= err2_d;
      start_q     <= start_d;
      cfg_valid_q <= cfg_valid_d;
    end
  end

  // Address capture, data-phase classification, FSM next state and bus outputs
  always_comb begin
    accept    = HSEL && HREADY && HTRANS[1] && (HADDR[31:5] == BASE_ADDR[31:5]);
    reg_idx   = offset_q[4:2];
    busy_now  = (state_q == ST_RUNNING);
    is_cfg    = (reg_idx == IDX_SIZE) || (reg_idx == IDX_SRC) || (reg_idx == IDX_DST);
    is_ctrl   = (reg_idx == IDX_CTRL);
    is_status = (reg_idx == IDX_STATUS);
    unmapped  = (offset_q[1:0] != 2'b00) || (reg_idx > IDX_STATUS);

    // Classification uses the state registered at the start of the data phase
    illegal = (size_q != 3'b010) || unmapped
           || (write_q && is_status)
           || (write_q && (is_cfg || is_ctrl) && busy_now)
           || (write_q && is_ctrl && HWDATA[0] && (cfg_valid_q != 3'b111));

    ok_now    = dphase_q && !illegal;
    wr_ok     = ok_now && write_q;
    cfg_en    = {wr_ok && (reg_idx == IDX_DST),
                 wr_ok && (reg_idx == IDX_SRC),
                 wr_ok && (reg_idx == IDX_SIZE)};
    start_req = wr_ok && is_ctrl && HWDATA[0];

    // A stalled bus (error cycle 1) blocks any new address phase
    dphase_d = accept;
    offset_d = offset_q;
    write_d  = write_q;
    size_d   = size_q;
    if (accept) begin
      offset_d = HADDR[4:0];
      write_d  = HWRITE;
      size_d   = HSIZE;
    end

    err2_d      = dphase_q && illegal;
    state_d     = state_q;
    start_d     = 1'b0;
    cfg_valid_d = cfg_valid_q | cfg_en;

    case (state_q)
      ST_IDLE: begin
        if (start_req) begin
          state_d = ST_RUNNING;
          start_d = 1'b1;
        end
      end
      ST_RUNNING: begin
        // A done arriving alongside the start pulse belongs to a previous run
        if (core_done && !start_q) begin
          state_d     = ST_IDLE;
          cfg_valid_d = 3'b000;
        end
      end
    endcase

    HREADYOUT = !(dphase_q && illegal);
    HRESP     = (dphase_q && illegal) || err2_q;
    HRDATA    = 32'h0;
    if (ok_now && !write_q && is_status) begin
      HRDATA = {27'b0, busy_now, 1'b0, cfg_valid_q};
    end

    decode_size_enable   = cfg_en[0];
    decode_source_enable = cfg_en[1];
    decode_dest_enable   = cfg_en[2];
    start                = start_q;
    busy                 = busy_now;
    cfg_valid            = cfg_valid_q;
  end

endmodule

// File: tb/tb_ahb_edge_ctrl.sv
// tb/tb_ahb_edge_ctrl.sv - self-checking bench for ahb_edge_ctrl
module tb_ahb_edge_ctrl;

  localparam int MAXC = 3000;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic        decode_size_enable;
  logic        decode_source_enable;
  logic        decode_dest_enable;
  logic        start;
  logic        core_done;
  logic        busy;
  logic [2:0]  cfg_valid;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_edge_ctrl #(.BASE_ADDR(32'h0000_0000)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .decode_size_enable(decode_size_enable), .decode_source_enable(decode_source_enable),
    .decode_dest_enable(decode_dest_enable), .start(start), .core_done(core_done),
    .busy(busy), .cfg_valid(cfg_valid)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [1:0]  trans;
    bit          done_dp;
    bit          rst_dp;
  } xfer_t;

  xfer_t q[$];

  // Expected timeline, one entry per clock cycle
  logic [2:0]  exp_cfg   [0:MAXC-1];
  logic        exp_busy  [0:MAXC-1];
  logic        exp_ready [0:MAXC-1];
  logic        exp_resp  [0:MAXC-1];
  logic [2:0]  exp_en    [0:MAXC-1];
  logic        exp_start [0:MAXC-1];
  logic        exp_rdv   [0:MAXC-1];
  logic [31:0] exp_rdata [0:MAXC-1];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;
  int cnt_size = 0, cnt_src = 0, cnt_dst = 0, cnt_start = 0, n_e1 = 0, n_e2 = 0;
  logic [31:0] cap_size, cap_src, cap_dst, last_rdata;
  logic [9:0]  act_v, exp_v;

  always @(posedge HCLK) cyc <= cyc + 1;

  always @(negedge HCLK) begin
    if (chk_on) begin
      act_v = {HREADYOUT, HRESP, decode_dest_enable, decode_source_enable, decode_size_enable, start, busy, cfg_valid};
      exp_v = {exp_ready[cyc], exp_resp[cyc], exp_en[cyc], exp_start[cyc], exp_busy[cyc], exp_cfg[cyc]};
      n_cmp++;
      if (act_v !== exp_v) begin
        n_err++;
        $display("FAIL cycle_outputs @%0d: got {rdy,resp,en3,start,busy,cfg3}=%b, expected %b", cyc, act_v, exp_v);
      end
      if (exp_rdv[cyc]) begin
        last_rdata = HRDATA;
        n_cmp++;
        if (HRDATA !== exp_rdata[cyc]) begin
          n_err++;
          $display("FAIL cycle_hrdata @%0d: got %h, expected %h", cyc, HRDATA, exp_rdata[cyc]);
        end
      end
      if (decode_size_enable)   begin cnt_size++; cap_size = HWDATA; end
      if (decode_source_enable) begin cnt_src++;  cap_src  = HWDATA; end
      if (decode_dest_enable)   begin cnt_dst++;  cap_dst  = HWDATA; end
      if (start) cnt_start++;
      if (HRESP && !HREADYOUT) n_e1++;
      if (HRESP && HREADYOUT)  n_e2++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic fill_state(input int from, input logic [2:0] cfg, input logic b);
    for (int i = from; i < MAXC; i++) begin
      exp_cfg[i]  = cfg;
      exp_busy[i] = b;
    end
  endtask

  task automatic clear_pulses(input int from);
    for (int i = from; i < MAXC; i++) begin
      exp_ready[i] = 1'b1;
      exp_resp[i]  = 1'b0;
      exp_en[i]    = 3'b000;
      exp_start[i] = 1'b0;
      exp_rdv[i]   = 1'b0;
      exp_rdata[i] = 32'h0;
    end
  endtask

  task automatic model_reset(input int c);
    fill_state(c + 1, 3'b000, 1'b0);
    clear_pulses(c + 1);
  endtask

  task automatic model_done(input int c);
    if (exp_busy[c] && !exp_start[c]) fill_state(c + 1, 3'b000, 1'b0);
  endtask

  function automatic bit model_err(input xfer_t x, input int c);
    logic [4:0] off;
    off = x.addr[4:0];
    if (x.size != 3'b010) return 1'b1;
    if (!(off == 5'h00 || off == 5'h04 || off == 5'h08 || off == 5'h0C || off == 5'h10)) return 1'b1;
    if (x.wr && off == 5'h10) return 1'b1;
    if (x.wr && exp_busy[c]) return 1'b1;
    if (x.wr && off == 5'h0C && x.data[0] && exp_cfg[c] != 3'b111) return 1'b1;
    return 1'b0;
  endfunction

  task automatic apply_ok(input xfer_t x, input int c);
    logic [4:0] off;
    logic [2:0] fb;
    off = x.addr[4:0];
    if (x.wr) begin
      if (off == 5'h00 || off == 5'h04 || off == 5'h08) begin
        fb = 3'b001 << off[3:2];
        exp_en[c] = fb;
        fill_state(c + 1, exp_cfg[c] | fb, exp_busy[c]);
      end else if (off == 5'h0C && x.data[0]) begin
        exp_start[c + 1] = 1'b1;
        fill_state(c + 1, exp_cfg[c], 1'b1);
      end
    end else begin
      exp_rdv[c]   = 1'b1;
      exp_rdata[c] = (off == 5'h10) ? {27'b0, exp_busy[c], 1'b0, exp_cfg[c]} : 32'h0;
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
    if (cyc >= MAXC - 5) begin
      $display("FAIL cycle_budget: cycle %0d reached limit %0d", cyc, MAXC - 5);
      $fatal(1);
    end
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic drive_idle();
    HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010;
  endtask

  task automatic push(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [31:0] d,
                      input logic [1:0] tr, input bit dn, input bit rs);
    xfer_t x;
    x.addr = a; x.wr = w; x.size = sz; x.data = d; x.trans = tr; x.done_dp = dn; x.rst_dp = rs;
    q.push_back(x);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    push(a, 1'b1, 3'b010, d, 2'b10, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a);
    push(a, 1'b0, 3'b010, 32'h0, 2'b10, 1'b0, 1'b0);
  endtask

  task automatic tick(input bit dn, input bit rs);
    int cc;
    cc = cyc;
    drive_idle();
    HWDATA = 32'h0; core_done = dn; HRESET = rs;
    if (rs) model_reset(cc);
    else if (dn) model_done(cc);
    step();
    core_done = 1'b0; HRESET = 1'b0;
  endtask

  // Pipelined master: address of the next transfer overlaps the data phase of the current one
  task automatic bus_run();
    xfer_t dp, nx;
    bit have_dp, have_nx, err;
    int cc;
    have_dp = 1'b0;
    while (q.size() > 0 || have_dp) begin
      cc = cyc;
      core_done = 1'b0; HRESET = 1'b0;
      have_nx = (q.size() > 0);
      if (have_nx) begin
        nx = q.pop_front();
        HSEL = 1'b1; HADDR = nx.addr; HTRANS = nx.trans; HWRITE = nx.wr; HSIZE = nx.size;
      end else begin
        drive_idle();
      end
      HWDATA = have_dp ? dp.data : 32'h0;
      if (have_dp) begin
        err = model_err(dp, cc);
        if (!err) apply_ok(dp, cc);
        if (dp.done_dp) begin
          core_done = 1'b1;
          model_done(cc);
        end
        if (err) begin
          exp_ready[cc] = 1'b0;
          exp_resp[cc]  = 1'b1;
          if (dp.rst_dp) begin
            HRESET = 1'b1;
            model_reset(cc);
            step();
            HRESET = 1'b0; core_done = 1'b0;
            if (have_nx) q.push_front(nx);
            have_dp = 1'b0;
          end else begin
            exp_resp[cc + 1] = 1'b1;
            step();
            core_done = 1'b0;
            step();
            have_dp = have_nx && nx.trans[1];
            dp = nx;
          end
        end else begin
          step();
          have_dp = have_nx && nx.trans[1];
          dp = nx;
        end
      end else begin
        step();
        have_dp = have_nx && nx.trans[1];
        dp = nx;
      end
    end
    drive_idle();
    core_done = 1'b0; HRESET = 1'b0; HWDATA = 32'h0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  initial begin
    int s0;
    HRESET = 1'b1; core_done = 1'b0; HWDATA = 32'h0;
    drive_idle();
    fill_state(0, 3'b000, 1'b0);
    clear_pulses(0);
    step();
    step();
    HRESET = 1'b0;
    chk_on = 1'b1;
    settle();
    lit("reset_hreadyout", {31'b0, HREADYOUT}, 32'h1);
    lit("reset_hresp", {31'b0, HRESP}, 32'h0);
    lit("reset_busy", {31'b0, busy}, 32'h0);
    lit("reset_cfg_valid", {29'b0, cfg_valid}, 32'h0);
    lit("reset_hrdata", HRDATA, 32'h0);

    // 1: back-to-back configuration writes
    wr(32'h00, 32'h00F0_0140);
    wr(32'h04, 32'h1000_0000);
    wr(32'h08, 32'h2000_0000);
    bus_run();
    settle();
    lit("t1_cfg_valid", {29'b0, cfg_valid}, 32'h7);
    lit("t1_size_pulses", cnt_size, 32'd1);
    lit("t1_src_pulses", cnt_src, 32'd1);
    lit("t1_dst_pulses", cnt_dst, 32'd1);
    lit("t1_size_data", cap_size, 32'h00F0_0140);
    lit("t1_src_data", cap_src, 32'h1000_0000);
    lit("t1_dst_data", cap_dst, 32'h2000_0000);

    // 2: start, done ignored in the start cycle, then a real done after 50 cycles
    wr(32'h0C, 32'h1);
    bus_run();
    tick(1'b1, 1'b0);
    last_rdata = 32'hFFFF_FFFF;
    rd(32'h10);
    bus_run();
    settle();
    lit("t2_status_running", last_rdata, 32'h0000_0017);
    lit("t2_start_pulses", cnt_start, 32'd1);
    repeat (46) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    settle();
    lit("t2_busy_after_done", {31'b0, busy}, 32'h0);
    lit("t2_cfg_after_done", {29'b0, cfg_valid}, 32'h0);
    last_rdata = 32'hFFFF_FFFF;
    rd(32'h10);
    bus_run();
    lit("t2_status_idle", last_rdata, 32'h0);

    // 3: premature start; the status read is presented across both error cycles
    wr(32'h00, 32'h00F0_0140);
    wr(32'h0C, 32'h1);
    rd(32'h10);
    last_rdata = 32'hFFFF_FFFF;
    bus_run();
    settle();
    lit("t3_cfg_valid", {29'b0, cfg_valid}, 32'h1);
    lit("t3_start_pulses", cnt_start, 32'd1);
    lit("t3_status", last_rdata, 32'h0000_0001);
    lit("t3_err_cycle1", n_e1, 32'd1);
    lit("t3_err_cycle2", n_e2, 32'd1);

    // 4: writes while running, including one coinciding with core_done
    wr(32'h04, 32'h1000_0000);
    wr(32'h08, 32'h2000_0000);
    wr(32'h0C, 32'h1);
    bus_run();
    repeat (3) tick(1'b0, 1'b0);
    s0 = cnt_src;
    wr(32'h04, 32'hDEAD_0000);
    bus_run();
    settle();
    lit("t4_src_blocked", cnt_src, s0);
    push(32'h04, 1'b1, 3'b010, 32'hDEAD_0000, 2'b10, 1'b1, 1'b0);
    bus_run();
    settle();
    lit("t4_src_blocked_at_done", cnt_src, s0);
    lit("t4_busy_cleared", {31'b0, busy}, 32'h0);
    wr(32'h04, 32'hDEAD_0000);
    bus_run();
    settle();
    lit("t4_src_after_done", cnt_src, s0 + 1);
    lit("t4_src_data", cap_src, 32'hDEAD_0000);
    lit("t4_cfg_valid", {29'b0, cfg_valid}, 32'h2);

    // 5: illegal accesses separated by IDLE and BUSY cycles
    s0 = n_e1;
    push(32'h00, 1'b1, 3'b000, 32'h0000_0055, 2'b10, 1'b0, 1'b0);
    push(32'h00, 1'b0, 3'b010, 32'h0, 2'b00, 1'b0, 1'b0);
    wr(32'h10, 32'hFFFF_FFFF);
    push(32'h04, 1'b1, 3'b010, 32'h0, 2'b01, 1'b0, 1'b0);
    rd(32'h18);
    bus_run();
    settle();
    lit("t5_err_count", n_e1, s0 + 3);
    lit("t5_cfg_valid", {29'b0, cfg_valid}, 32'h2);
    lit("t5_size_pulses", cnt_size, 32'd2);

    // 6: reset during error cycle 1, then during RUNNING
    push(32'h00, 1'b1, 3'b000, 32'h1, 2'b10, 1'b0, 1'b1);
    bus_run();
    settle();
    lit("t6_err_reset_ready", {31'b0, HREADYOUT}, 32'h1);
    lit("t6_err_reset_resp", {31'b0, HRESP}, 32'h0);
    lit("t6_err_reset_cfg", {29'b0, cfg_valid}, 32'h0);
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h2);
    wr(32'h08, 32'h3);
    wr(32'h0C, 32'h1);
    bus_run();
    repeat (2) tick(1'b0, 1'b0);
    settle();
    lit("t6_running", {31'b0, busy}, 32'h1);
    tick(1'b0, 1'b1);
    settle();
    lit("t6_run_reset_busy", {31'b0, busy}, 32'h0);
    lit("t6_run_reset_cfg", {29'b0, cfg_valid}, 32'h0);
    s0 = cnt_start;
    tick(1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0);
    settle();
    lit("t6_late_done_busy", {31'b0, busy}, 32'h0);
    lit("t6_late_done_cfg", {29'b0, cfg_valid}, 32'h0);
    lit("t6_no_start", cnt_start, s0);

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
